// File: rtl/camera_ray_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// camera_ray_gen : raster-order primary ray generator (Q8.24 directions)
// Revision 1.0
// ----------------------------------------------------------------------------
module camera_ray_gen #(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [95:0] camera_origin,
  input  logic [95:0] dir_top_left,
  input  logic [95:0] dir_step_x,
  input  logic [95:0] dir_step_y,
  input  logic        stall_source,
  output logic [10:0] image_x,
  output logic [10:0] image_y,
  output logic [95:0] casted_ray_origin,
  output logic [95:0] casted_ray_direction,
  output logic        new_data,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [10:0] X_LAST = 11'(IMAGE_WIDTH - 1);
  localparam logic [10:0] Y_LAST = 11'(IMAGE_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [10:0] x, y;
  logic [95:0] origin, step_x, step_y, row_dir, cur_dir;
  logic [95:0] next_row;
  logic        accept, x_end, y_end;

  // Three independent 32-bit lanes; carries never cross lane boundaries.
  function automatic logic [95:0] lane_add(input logic [95:0] a, input logic [95:0] b);
    logic [95:0] r;
    for (int i = 0; i < 3; i++) begin
      r[i*32 +: 32] = a[i*32 +: 32] + b[i*32 +: 32];
    end
    return r;
  endfunction

  assign accept   = (state == ISSUE) && !stall_source;
  assign x_end    = (x == X_LAST);
  assign y_end    = (y == Y_LAST);
  assign next_row = lane_add(row_dir, step_y);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ISSUE;
      ISSUE:   if (accept && x_end && y_end) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x       <= '0;
      y       <= '0;
      origin  <= '0;
      step_x  <= '0;
      step_y  <= '0;
      row_dir <= '0;
      cur_dir <= '0;
    end else if (state == IDLE && start) begin
      x       <= '0;
      y       <= '0;
      origin  <= camera_origin;
      step_x  <= dir_step_x;
      step_y  <= dir_step_y;
      row_dir <= dir_top_left;
      cur_dir <= dir_top_left;
    end else if (accept) begin
      if (!x_end) begin
        x       <= x + 11'd1;
        cur_dir <= lane_add(cur_dir, step_x);
      end else if (!y_end) begin
        x       <= '0;
        y       <= y + 11'd1;
        row_dir <= next_row;
        cur_dir <= next_row;
      end
    end
  end

  assign image_x              = x;
  assign image_y              = y;
  assign casted_ray_origin    = origin;
  assign casted_ray_direction = cur_dir;
  assign new_data             = accept;
  assign busy                 = (state != IDLE);
  assign frame_done           = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_camera_ray_gen.sv
`default_nettype none
// Directed bench for camera_ray_gen: 2x2, 4x4 and 1x1 instances share the
// frame inputs and stall but each has its own start.
module tb_camera_ray_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start22 = 1'b0, start44 = 1'b0, start11 = 1'b0;
  logic        stall = 1'b0;
  logic [95:0] camera_origin = '0, dir_top_left = '0, dir_step_x = '0, dir_step_y = '0;

  logic [10:0] x22, y22, x44, y44, x11, y11;
  logic [95:0] org22, dir22, org44, dir44, org11, dir11;
  logic        nd22, busy22, fd22, nd44, busy44, fd44, nd11, busy11, fd11;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  camera_ray_gen #(.IMAGE_WIDTH(2), .IMAGE_HEIGHT(2)) u_dut22 (
    .clk(clk), .rst(rst), .start(start22), .camera_origin(camera_origin),
    .dir_top_left(dir_top_left), .dir_step_x(dir_step_x), .dir_step_y(dir_step_y),
    .stall_source(stall), .image_x(x22), .image_y(y22), .casted_ray_origin(org22),
    .casted_ray_direction(dir22), .new_data(nd22), .busy(busy22), .frame_done(fd22));

  camera_ray_gen #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(4)) u_dut44 (
    .clk(clk), .rst(rst), .start(start44), .camera_origin(camera_origin),
    .dir_top_left(dir_top_left), .dir_step_x(dir_step_x), .dir_step_y(dir_step_y),
    .stall_source(stall), .image_x(x44), .image_y(y44), .casted_ray_origin(org44),
    .casted_ray_direction(dir44), .new_data(nd44), .busy(busy44), .frame_done(fd44));

  camera_ray_gen #(.IMAGE_WIDTH(1), .IMAGE_HEIGHT(1)) u_dut11 (
    .clk(clk), .rst(rst), .start(start11), .camera_origin(camera_origin),
    .dir_top_left(dir_top_left), .dir_step_x(dir_step_x), .dir_step_y(dir_step_y),
    .stall_source(stall), .image_x(x11), .image_y(y11), .casted_ray_origin(org11),
    .casted_ray_direction(dir11), .new_data(nd11), .busy(busy11), .frame_done(fd11));

  // Q8.24 constants: -1.0, 1.0, 2.0, 5.0, -5.0
  localparam logic [31:0] M1 = 32'hFF000000;
  localparam logic [31:0] P1 = 32'h01000000;
  localparam logic [31:0] P2 = 32'h02000000;
  localparam logic [31:0] P5 = 32'h05000000;
  localparam logic [31:0] M5 = 32'hFB000000;

  logic [95:0] exp_dir [4];
  logic [10:0] exp_x   [4];
  logic [10:0] exp_y   [4];

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic load_2x2_inputs;
    camera_origin = {M5, 32'h0, 32'h0};
    dir_top_left  = {P5, M1, M1};
    dir_step_x    = {32'h0, 32'h0, P2};
    dir_step_y    = {32'h0, P2, 32'h0};
    exp_dir[0] = {P5, M1, M1}; exp_x[0] = 11'd0; exp_y[0] = 11'd0;
    exp_dir[1] = {P5, M1, P1}; exp_x[1] = 11'd1; exp_y[1] = 11'd0;
    exp_dir[2] = {P5, P1, M1}; exp_x[2] = 11'd0; exp_y[2] = 11'd1;
    exp_dir[3] = {P5, P1, P1}; exp_x[3] = 11'd1; exp_y[3] = 11'd1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    compared++;
    if ({x22, y22, org22, dir22, nd22, busy22, fd22} !== '0) begin
      mismatched++;
      $display("FAIL reset_2x2: got x=%0d y=%0d org=%h dir=%h nd=%b busy=%b fd=%b, expected all zero",
               x22, y22, org22, dir22, nd22, busy22, fd22);
    end
    compared++;
    if ({nd44, busy44, fd44, dir44, nd11, busy11, fd11, dir11} !== '0) begin
      mismatched++;
      $display("FAIL reset_others: got nd44=%b busy44=%b fd44=%b nd11=%b busy11=%b fd11=%b, expected zero",
               nd44, busy44, fd44, nd11, busy11, fd11);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_unstalled_2x2;
    load_2x2_inputs();
    stall = 1'b0;
    start22 = 1'b1; tick; start22 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      compared++;
      if ({nd22, busy22, x22, y22, dir22, org22} !== {2'b11, exp_x[i], exp_y[i], exp_dir[i], {M5, 64'h0}}) begin
        mismatched++;
        $display("FAIL unstalled_ray%0d: got nd=%b busy=%b (%0d,%0d) dir=%h org=%h, expected nd=1 busy=1 (%0d,%0d) dir=%h",
                 i, nd22, busy22, x22, y22, dir22, org22, exp_x[i], exp_y[i], exp_dir[i]);
      end
      tick;
    end
    compared++;
    if ({fd22, nd22, busy22} !== 3'b101) begin
      mismatched++;
      $display("FAIL unstalled_done: got fd=%b nd=%b busy=%b, expected fd=1 nd=0 busy=1", fd22, nd22, busy22);
    end
    tick;
    compared++;
    if ({fd22, nd22, busy22} !== 3'b000) begin
      mismatched++;
      $display("FAIL unstalled_idle: got fd=%b nd=%b busy=%b, expected 000", fd22, nd22, busy22);
    end
  endtask

  task automatic test_stall;
    load_2x2_inputs();
    stall = 1'b0;
    start22 = 1'b1; tick; start22 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      compared++;
      if ({nd22, x22, y22, dir22} !== {1'b1, exp_x[i], exp_y[i], exp_dir[i]}) begin
        mismatched++;
        $display("FAIL stall_pre_ray%0d: got nd=%b (%0d,%0d) dir=%h, expected nd=1 (%0d,%0d) dir=%h",
                 i, nd22, x22, y22, dir22, exp_x[i], exp_y[i], exp_dir[i]);
      end
      tick;
    end
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      compared++;
      if ({nd22, busy22, x22, y22, dir22} !== {2'b01, 11'd0, 11'd1, exp_dir[2]}) begin
        mismatched++;
        $display("FAIL stall_hold%0d: got nd=%b busy=%b (%0d,%0d) dir=%h, expected nd=0 busy=1 (0,1) dir=%h",
                 k, nd22, busy22, x22, y22, dir22, exp_dir[2]);
      end
      tick;
    end
    stall = 1'b0;
    for (int i = 2; i < 4; i++) begin
      #1;
      compared++;
      if ({nd22, x22, y22, dir22} !== {1'b1, exp_x[i], exp_y[i], exp_dir[i]}) begin
        mismatched++;
        $display("FAIL stall_post_ray%0d: got nd=%b (%0d,%0d) dir=%h, expected nd=1 (%0d,%0d) dir=%h",
                 i, nd22, x22, y22, dir22, exp_x[i], exp_y[i], exp_dir[i]);
      end
      tick;
    end
    compared++;
    if ({fd22, nd22} !== 2'b10) begin
      mismatched++;
      $display("FAIL stall_done: got fd=%b nd=%b, expected fd=1 nd=0", fd22, nd22);
    end
    tick;
  endtask

  task automatic test_reset_mid_frame;
    camera_origin = {32'h0, 32'h0, 32'h0A000000};
    dir_top_left  = {32'h00300000, 32'h00200000, 32'h00100000};
    dir_step_x    = {32'h0, 32'h0, 32'h00010000};
    dir_step_y    = {32'h0, 32'h00020000, 32'h0};
    stall = 1'b0;
    start44 = 1'b1; tick; start44 = 1'b0;
    repeat (5) tick;
    compared++;
    if ({nd44, x44, y44, dir44} !== {1'b1, 11'd1, 11'd1, 32'h00300000, 32'h00220000, 32'h00110000}) begin
      mismatched++;
      $display("FAIL midframe_ray5: got nd=%b (%0d,%0d) dir=%h, expected nd=1 (1,1) dir=003000000022000000110000",
               nd44, x44, y44, dir44);
    end
    rst = 1'b1;
    #1;
    compared++;
    if ({x44, y44, org44, dir44, nd44, busy44, fd44} !== '0) begin
      mismatched++;
      $display("FAIL midframe_reset: got (%0d,%0d) org=%h dir=%h nd=%b busy=%b fd=%b, expected all zero",
               x44, y44, org44, dir44, nd44, busy44, fd44);
    end
    tick;
    rst = 1'b0;
    camera_origin = {32'h0, 32'h0, 32'h12345678};
    dir_top_left  = {32'h0, 32'h0, 32'h01000000};
    tick;
    start44 = 1'b1; tick; start44 = 1'b0;
    compared++;
    if ({nd44, x44, y44, dir44, org44} !== {1'b1, 11'd0, 11'd0, 32'h0, 32'h0, 32'h01000000, 64'h0, 32'h12345678}) begin
      mismatched++;
      $display("FAIL restart_ray0: got nd=%b (%0d,%0d) dir=%h org=%h, expected nd=1 (0,0) dir=%h org=%h",
               nd44, x44, y44, dir44, org44, {64'h0, 32'h01000000}, {64'h0, 32'h12345678});
    end
    tick;
    compared++;
    if ({nd44, x44, y44, dir44} !== {1'b1, 11'd1, 11'd0, 64'h0, 32'h01010000}) begin
      mismatched++;
      $display("FAIL restart_ray1: got nd=%b (%0d,%0d) dir=%h, expected nd=1 (1,0) dir=%h",
               nd44, x44, y44, dir44, {64'h0, 32'h01010000});
    end
    for (int c = 0; c < 40 && !fd44; c++) tick;
    compared++;
    if (fd44 !== 1'b1) begin
      mismatched++;
      $display("FAIL restart_done_timeout: got fd=%b, expected fd=1 within 40 cycles", fd44);
    end
    tick;
  endtask

  task automatic test_start_while_busy;
    int n;
    n = 0;
    load_2x2_inputs();
    stall = 1'b0;
    start22 = 1'b1; tick; start22 = 1'b0;
    for (int c = 0; c < 12 && !fd22; c++) begin
      start22 = (c == 1);
      camera_origin = (c >= 1) ? {32'h11111111, 32'h22222222, 32'h33333333} : {M5, 64'h0};
      dir_top_left  = (c >= 1) ? {32'h0, 32'h0, 32'h0} : {P5, M1, M1};
      #1;
      if (nd22) begin
        compared++;
        if (n >= 4 || {org22, dir22} !== {M5, 64'h0, exp_dir[n]}) begin
          mismatched++;
          $display("FAIL busy_start_ray%0d: got org=%h dir=%h, expected org=%h dir=%h",
                   n, org22, dir22, {M5, 64'h0}, exp_dir[n % 4]);
        end
        n++;
      end
      tick;
    end
    start22 = 1'b0;
    compared++;
    if (fd22 !== 1'b1 || n != 4) begin
      mismatched++;
      $display("FAIL busy_start_count: got fd=%b rays=%0d, expected fd=1 rays=4", fd22, n);
    end
    start22 = 1'b1; tick; start22 = 1'b0;
    #1;
    compared++;
    if ({busy22, nd22, fd22} !== 3'b000) begin
      mismatched++;
      $display("FAIL done_cycle_start: got busy=%b nd=%b fd=%b, expected 000", busy22, nd22, fd22);
    end
    tick;
    compared++;
    if (busy22 !== 1'b0) begin
      mismatched++;
      $display("FAIL done_cycle_start_late: got busy=%b, expected 0", busy22);
    end
  endtask

  task automatic test_wrap;
    camera_origin = '0;
    dir_top_left  = {P5, 32'hFFFFFFFF, 32'h7F000000};
    dir_step_x    = {32'h0, 32'h0, P2};
    dir_step_y    = {32'h0, 32'h00000001, 32'h0};
    stall = 1'b0;
    start22 = 1'b1; tick; start22 = 1'b0;
    tick;
    compared++;
    if ({nd22, dir22} !== {1'b1, P5, 32'hFFFFFFFF, 32'h81000000}) begin
      mismatched++;
      $display("FAIL wrap_ray1: got nd=%b dir=%h, expected nd=1 dir=%h", nd22, dir22, {P5, 32'hFFFFFFFF, 32'h81000000});
    end
    tick;
    compared++;
    if ({nd22, dir22} !== {1'b1, P5, 32'h0, 32'h7F000000}) begin
      mismatched++;
      $display("FAIL wrap_ray2: got nd=%b dir=%h, expected nd=1 dir=%h", nd22, dir22, {P5, 32'h0, 32'h7F000000});
    end
    tick;
    compared++;
    if ({nd22, dir22} !== {1'b1, P5, 32'h0, 32'h81000000}) begin
      mismatched++;
      $display("FAIL wrap_ray3: got nd=%b dir=%h, expected nd=1 dir=%h", nd22, dir22, {P5, 32'h0, 32'h81000000});
    end
    tick; tick;
  endtask

  task automatic test_1x1;
    camera_origin = {32'h0, 32'h0, 32'h00ABCDEF};
    dir_top_left  = {32'h01020304, 32'h05060708, 32'h090A0B0C};
    dir_step_x    = {32'h0, 32'h0, P1};
    dir_step_y    = {32'h0, P1, 32'h0};
    stall = 1'b0;
    start11 = 1'b1; tick; start11 = 1'b0;
    compared++;
    if ({nd11, x11, y11, dir11, org11} !== {1'b1, 22'd0, 32'h01020304, 32'h05060708, 32'h090A0B0C, 64'h0, 32'h00ABCDEF}) begin
      mismatched++;
      $display("FAIL one_by_one_ray: got nd=%b (%0d,%0d) dir=%h org=%h, expected nd=1 (0,0) dir=010203040506070809 0a0b0c",
               nd11, x11, y11, dir11, org11);
    end
    tick;
    compared++;
    if ({fd11, nd11, busy11} !== 3'b101) begin
      mismatched++;
      $display("FAIL one_by_one_done: got fd=%b nd=%b busy=%b, expected fd=1 nd=0 busy=1", fd11, nd11, busy11);
    end
    tick;
    compared++;
    if ({fd11, nd11, busy11} !== 3'b000) begin
      mismatched++;
      $display("FAIL one_by_one_idle: got fd=%b nd=%b busy=%b, expected 000", fd11, nd11, busy11);
    end
  endtask

  initial begin
    test_reset();
    test_unstalled_2x2();
    test_stall();
    test_reset_mid_frame();
    test_start_while_busy();
    test_wrap();
    test_1x1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
